// File: rtl/led_pkg.sv
// Shared state encoding and default WS2812 timing, in clocks at 50 MHz.
package led_pkg;

  typedef enum logic [1:0] {
    LATCH = 2'd0,
    IDLE  = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } led_state_e;

  localparam int LED_T0H  = 20;
  localparam int LED_T1H  = 40;
  localparam int LED_TBIT = 63;
  localparam int LED_TRST = 2600;
  localparam int LED_BITS = 24;

  function automatic int led_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Phase counter: counts clocks since the last load and flags the last clock of a phase.
module led_bit_timer #(
  parameter int CW = 12
) (
  input  logic          csi_MCLK_clk,
  input  logic          rsi_MRST_reset_n,
  input  logic          load,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_reg;

  // Holds at the terminal value instead of wrapping if no load arrives.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (!tc) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == limit - CW'(1));

endmodule

// File: rtl/led_ws2812_sink.sv
// Avalon-ST pixel sink driving a WS2812 chain; pixels arriving in the last clock of a frame chain seamlessly.
module led_ws2812_sink
  import led_pkg::*;
#(
  parameter int T0H  = LED_T0H,
  parameter int T1H  = LED_T1H,
  parameter int TBIT = LED_TBIT,
  parameter int TRST = LED_TRST
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset_n,
  input  logic [23:0] asi_LEDS_data,
  input  logic        asi_LEDS_valid,
  output logic        asi_LEDS_ready,
  output logic        coe_LED_dout
);

  localparam int            CW       = $clog2(led_max(TBIT, TRST) + 1);
  localparam logic [CW-1:0] HI0_LEN  = CW'(T0H);
  localparam logic [CW-1:0] HI1_LEN  = CW'(T1H);
  localparam logic [CW-1:0] LO0_LEN  = CW'(TBIT - T0H);
  localparam logic [CW-1:0] LO1_LEN  = CW'(TBIT - T1H);
  localparam logic [CW-1:0] RST_LEN  = CW'(TRST);
  localparam logic [4:0]    LAST_BIT = 5'(LED_BITS - 1);

  led_state_e    state_reg, state_next;
  logic [23:0]   shift_reg, shift_next;
  logic [4:0]    bit_idx_reg, bit_idx_next;
  logic          dout_reg, dout_next;
  logic          ready_reg, ready_next;
  logic          timer_load, timer_tc, accept;
  logic [CW-1:0] timer_count, timer_limit, count_next, low_len;
  logic [23:0]   grb;

  assign accept  = asi_LEDS_valid && ready_reg;
  assign grb     = {asi_LEDS_data[15:8], asi_LEDS_data[23:16], asi_LEDS_data[7:0]};
  assign low_len = shift_reg[23] ? LO1_LEN : LO0_LEN;

  always_comb begin
    case (state_reg)
      HIGH:    timer_limit = shift_reg[23] ? HI1_LEN : HI0_LEN;
      LOW:     timer_limit = low_len;
      default: timer_limit = RST_LEN;
    endcase
  end

  led_bit_timer #(.CW(CW)) u_timer (
    .csi_MCLK_clk     (csi_MCLK_clk),
    .rsi_MRST_reset_n (rsi_MRST_reset_n),
    .load             (timer_load),
    .limit            (timer_limit),
    .count            (timer_count),
    .tc               (timer_tc)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    timer_load   = 1'b0;
    case (state_reg)
      LATCH: begin
        if (timer_tc) begin
          state_next = IDLE;
          timer_load = 1'b1;
        end
      end
      IDLE: begin
        if (accept) begin
          state_next   = HIGH;
          shift_next   = grb;
          bit_idx_next = '0;
          timer_load   = 1'b1;
        end
      end
      HIGH: begin
        if (timer_tc) begin
          state_next = LOW;
          timer_load = 1'b1;
        end
      end
      LOW: begin
        if (timer_tc) begin
          timer_load = 1'b1;
          if (bit_idx_reg != LAST_BIT) begin
            state_next   = HIGH;
            shift_next   = {shift_reg[22:0], 1'b0};
            bit_idx_next = bit_idx_reg + 5'd1;
          end else if (accept) begin
            state_next   = HIGH;
            shift_next   = grb;
            bit_idx_next = '0;
          end else begin
            state_next = LATCH;
          end
        end
      end
      default: begin
        state_next = LATCH;
        timer_load = 1'b1;
      end
    endcase

    // Outputs are registered, so they are derived from where the FSM will be next clock.
    count_next = timer_load ? '0 : (timer_tc ? timer_count : timer_count + CW'(1));
    dout_next  = (state_next == HIGH);
    ready_next = (state_next == IDLE) ||
                 ((state_next == LOW) && (bit_idx_next == LAST_BIT) &&
                  (count_next == low_len - CW'(1)));
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state_reg   <= LATCH;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      dout_reg    <= 1'b0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      dout_reg    <= dout_next;
      ready_reg   <= ready_next;
    end
  end

  assign asi_LEDS_ready = ready_reg;
  assign coe_LED_dout   = dout_reg;

endmodule

// File: tb/tb_led_ws2812_sink.sv
// Bench for led_ws2812_sink: cycle model of the serial line plus a waveform decoder scoreboard.
module tb_led_ws2812_sink;

  localparam int T0H   = 20;
  localparam int T1H   = 40;
  localparam int TBIT  = 63;
  localparam int TRST  = 2600;
  localparam int NBITS = 24;
  localparam int FRAME = NBITS * TBIT;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic [23:0] data  = '0;
  logic        ready;
  logic        dout;

  int vectors     = 0;
  int miscompares = 0;

  led_ws2812_sink #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST)) dut (
    .csi_MCLK_clk     (clk),
    .rsi_MRST_reset_n (rst_n),
    .asi_LEDS_data    (data),
    .asi_LEDS_valid   (valid),
    .asi_LEDS_ready   (ready),
    .coe_LED_dout     (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] wire_order(input logic [23:0] d);
    return {d[15:8], d[23:16], d[7:0]};
  endfunction

  // Reference model: position within a pixel frame, or within the latch gap.
  typedef enum logic [1:0] {M_LATCH, M_IDLE, M_PIX} mmode_e;
  mmode_e      m_mode     = M_LATCH;
  int          m_cnt      = 0;
  logic [23:0] m_pix      = '0;
  int          accept_cnt = 0;
  logic [23:0] exp_q[$];

  function automatic logic m_ready();
    return rst_n && ((m_mode == M_IDLE) || ((m_mode == M_PIX) && (m_cnt == FRAME - 1)));
  endfunction

  function automatic logic m_dout();
    int hi;
    if (!rst_n || m_mode != M_PIX) return 1'b0;
    hi = m_pix[NBITS - 1 - m_cnt / TBIT] ? T1H : T0H;
    return (m_cnt % TBIT) < hi;
  endfunction

  always @(posedge clk) begin
    logic acc;
    if (!rst_n) begin
      m_mode = M_LATCH;
      m_cnt  = 0;
      exp_q.delete();
    end else begin
      acc = valid && m_ready();
      if (acc) begin
        accept_cnt++;
        exp_q.push_back(wire_order(data));
      end
      case (m_mode)
        M_LATCH: begin
          m_cnt++;
          if (m_cnt == TRST) m_mode = M_IDLE;
        end
        M_IDLE: begin
          if (acc) begin
            m_mode = M_PIX;
            m_cnt  = 0;
            m_pix  = wire_order(data);
          end
        end
        default: begin
          if (m_cnt == FRAME - 1) begin
            m_cnt = 0;
            if (acc) m_pix = wire_order(data);
            else     m_mode = M_LATCH;
          end else begin
            m_cnt++;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic ed, er;
    ed = m_dout();
    er = m_ready();
    vectors++;
    if (dout !== ed || ready !== er) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t dout=%b ready=%b expected dout=%b ready=%b",
               $time, dout, ready, ed, er);
    end
  end

  // Decoder: measures high widths and bit periods on the line and rebuilds each pixel.
  logic        prev = 1'b0;
  logic        pending = 1'b0;
  int          hi_cnt = 0, per_cnt = 0, nb = 0, run_bits = 0, last_run_bits = 0, dec_cnt = 0;
  logic [23:0] shreg = '0, last_dec = '0;

  always @(negedge clk) begin
    logic [23:0] expv;
    if (!rst_n) begin
      prev = 1'b0; pending = 1'b0; hi_cnt = 0; per_cnt = 0; nb = 0; run_bits = 0;
    end else begin
      if (dout && !prev) begin
        if (pending) begin
          vectors++;
          if (per_cnt != TBIT) begin
            miscompares++;
            $display("FAIL bit_period got %0d want %0d", per_cnt, TBIT);
          end
        end else begin
          run_bits = 0;
        end
        pending = 1'b1; per_cnt = 1; hi_cnt = 1;
      end else begin
        per_cnt++;
        if (dout) hi_cnt++;
      end
      if (!dout && prev) begin
        vectors++;
        if (hi_cnt != T0H && hi_cnt != T1H) begin
          miscompares++;
          $display("FAIL high_width got %0d want %0d or %0d", hi_cnt, T0H, T1H);
        end
        shreg = {shreg[22:0], (hi_cnt == T1H)};
        nb++;
        run_bits++;
        if (nb == NBITS) begin
          nb = 0;
          dec_cnt++;
          last_dec = shreg;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL frame_unexpected got %06h want none", shreg);
          end else begin
            expv = exp_q.pop_front();
            if (shreg !== expv) begin
              miscompares++;
              $display("FAIL frame_grb got %06h want %06h", shreg, expv);
            end
          end
          $display("frame %0d: decoded GRB %06h", dec_cnt, shreg);
        end
      end
      if (!dout && pending && per_cnt > TBIT) begin
        pending = 1'b0;
        last_run_bits = run_bits;
      end
      prev = dout;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [23:0] d, input bit hold);
    int  start;
    bit  done;
    start = accept_cnt;
    done  = 1'b0;
    valid = 1'b1;
    data  = d;
    for (int i = 0; i < TRST + FRAME + 100 && !done; i++) begin
      tick();
      if (accept_cnt != start) done = 1'b1;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL accept_timeout got none want beat %06h", d);
    end
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 3 * (FRAME + TBIT) && dec_cnt < target; i++) tick();
    if (dec_cnt < target) begin
      miscompares++;
      $display("FAIL frame_timeout got %0d want %0d", dec_cnt, target);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < FRAME + TRST + 200 && m_mode != M_IDLE; i++) tick();
    if (m_mode != M_IDLE) begin
      miscompares++;
      $display("FAIL idle_timeout got mode %0d want idle", m_mode);
    end
  endtask

  task automatic measure_latch(output int n);
    n = 0;
    for (int i = 0; i < TRST + 50; i++) begin
      @(negedge clk);
      if (ready) break;
      n++;
    end
  endtask

  typedef struct {
    logic [23:0] pix;
    logic [23:0] exp_grb;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   n, dec0, acc0;

    tbl[0] = '{24'hFF0000, 24'h00FF00};
    tbl[1] = '{24'h123456, 24'h341256};
    tbl[2] = '{24'h000000, 24'h000000};
    tbl[3] = '{24'hFFFFFF, 24'hFFFFFF};
    tbl[4] = '{24'hA5C30F, 24'hC3A50F};

    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("reset_dout", dout, 0);
    check("reset_ready", ready, 0);
    rst_n = 1'b1;
    measure_latch(n);
    check("latch_after_reset", n, TRST);
    tick();
    check("idle_dout", dout, 0);
    check("idle_ready", ready, 1);

    for (int i = 0; i < 5; i++) begin
      dec0 = dec_cnt;
      send_beat(tbl[i].pix, 1'b0);
      data = $urandom;
      wait_frames(dec0 + 1);
      check("table_grb", last_dec, tbl[i].exp_grb);
      wait_idle();
    end

    // Two beats back to back with valid held high.
    dec0 = dec_cnt;
    acc0 = accept_cnt;
    send_beat(24'h00FF00, 1'b1);
    send_beat(24'h0000FF, 1'b0);
    wait_frames(dec0 + 2);
    check("chain_second_grb", last_dec, 24'h0000FF);
    wait_idle();
    check("chain_run_bits", last_run_bits, 2 * NBITS);
    check("chain_accepts", accept_cnt, acc0 + 2);

    // Valid and data thrash while the sink is busy.
    dec0 = dec_cnt;
    acc0 = accept_cnt;
    send_beat(24'h3C5A96, 1'b0);
    for (int i = 0; i < 1200; i++) begin
      tick();
      valid = 1'($urandom_range(0, 1));
      data  = $urandom;
    end
    valid = 1'b0;
    wait_frames(dec0 + 1);
    check("busy_grb", last_dec, 24'h5A3C96);
    wait_idle();
    check("busy_accepts", accept_cnt, acc0 + 1);

    // Reset in the middle of bit 10, then a clean pixel.
    dec0 = dec_cnt;
    send_beat(24'hAAAAAA, 1'b0);
    repeat (10 * TBIT + 5) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_dout", dout, 0);
    check("abort_ready", ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    measure_latch(n);
    check("latch_after_abort", n, TRST);
    check("abort_no_frame", dec_cnt, dec0);
    send_beat(24'h123456, 1'b0);
    wait_frames(dec0 + 1);
    check("after_abort_grb", last_dec, 24'h341256);
    wait_idle();

    // Random valid/data traffic against the model and decoder.
    for (int i = 0; i < 4000; i++) begin
      tick();
      valid = ($urandom_range(0, 3) == 0);
      data  = $urandom;
    end
    valid = 1'b0;
    wait_idle();
    check("random_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
